// File: rtl/capsense_pkg.sv
// rtl/capsense_pkg.sv - event kind codes and scanner states shared by the capsense event decoder
package capsense_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/capsense_evt_fifo.sv
// rtl/capsense_evt_fifo.sv - synchronous event FIFO; a push into a full FIFO is taken only if a pop frees a slot
module capsense_evt_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, rptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/capsense_event_decoder.sv
// rtl/capsense_event_decoder.sv - debounce, long-press detect and event queue for capsense buttons
// Optional toggle_o output enabled by CAPSENSE_TOGGLE_EN.
module capsense_event_decoder
    import capsense_pkg::*;
#(
    parameter int N            = 4,
    parameter int DEB_SAMPLES  = 3,
    parameter int LONG_SAMPLES = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_stb_i,
    input  logic [N-1:0]         buttons_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [$clog2(N)-1:0] evt_btn_o,
    output logic [1:0]           evt_kind_o,
    output logic [N-1:0]         state_o,
    output logic                 overflow_o,
    input  logic                 clear_ovf_i
`ifdef CAPSENSE_TOGGLE_EN
    ,
    output logic [N-1:0]         toggle_o
`endif
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEB_SAMPLES) + 1;
    localparam int HW = $clog2(LONG_SAMPLES + 1);

    logic [N-1:0]  state_q, rise, fall, long_hit;
    logic [CW-1:0] deb_cnt [N];
    logic [HW-1:0] hold [N];

    logic [N-1:0]  pend_press, pend_rel, pend_long;
    logic [N-1:0]  cons_press, cons_rel, cons_long, rem_all;
    scan_state_t   scan_q, scan_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          push, pop, ovf_set;
    logic [1:0]    push_kind;
    logic          fifo_full, fifo_empty;
    logic [IW+1:0] fifo_rdata;

    // A long press is not reported on the strobe that releases the button.
    always_comb begin
        rise     = '0;
        fall     = '0;
        long_hit = '0;
        for (int i = 0; i < N; i++) begin
            if (sample_stb_i && (buttons_i[i] != state_q[i]) &&
                (deb_cnt[i] == CW'(DEB_SAMPLES - 1))) begin
                rise[i] = buttons_i[i];
                fall[i] = !buttons_i[i];
            end
            long_hit[i] = sample_stb_i && state_q[i] && !fall[i] &&
                          (hold[i] == HW'(LONG_SAMPLES - 1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
            for (int i = 0; i < N; i++) begin
                deb_cnt[i] <= '0;
                hold[i]    <= '0;
            end
        end else if (sample_stb_i) begin
            for (int i = 0; i < N; i++) begin
                if (buttons_i[i] == state_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_SAMPLES - 1)) begin
                    deb_cnt[i] <= '0;
                    state_q[i] <= buttons_i[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
                if (rise[i]) begin
                    hold[i] <= '0;
                end else if (state_q[i] && (hold[i] != HW'(LONG_SAMPLES))) begin
                    hold[i] <= hold[i] + 1'b1;
                end
            end
        end
    end

    // Scanner: one event per cycle; idx moves on once its button has nothing left after this cycle.
    always_comb begin
        scan_d     = scan_q;
        idx_d      = idx_q;
        push       = 1'b0;
        push_kind  = EVT_PRESS;
        cons_press = '0;
        cons_long  = '0;
        cons_rel   = '0;
        if (scan_q == SCAN) begin
            if (pend_press[idx_q]) begin
                push              = 1'b1;
                push_kind         = EVT_PRESS;
                cons_press[idx_q] = 1'b1;
            end else if (pend_long[idx_q]) begin
                push             = 1'b1;
                push_kind        = EVT_LONG;
                cons_long[idx_q] = 1'b1;
            end else if (pend_rel[idx_q]) begin
                push            = 1'b1;
                push_kind       = EVT_RELEASE;
                cons_rel[idx_q] = 1'b1;
            end
        end
        rem_all = (pend_press & ~cons_press) | (pend_long & ~cons_long) | (pend_rel & ~cons_rel);
        case (scan_q)
            IDLE: begin
                if (|rem_all) begin
                    scan_d = SCAN;
                    idx_d  = '0;
                end
            end
            SCAN: begin
                if (!rem_all[idx_q]) begin
                    if (idx_q == IW'(N - 1)) begin
                        idx_d = '0;
                        if (!(|rem_all)) begin
                            scan_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: scan_d = IDLE;
        endcase
    end

    assign pop     = evt_valid_o && evt_ready_i;
    assign ovf_set = (|(rise & pend_press)) || (|(fall & pend_rel)) ||
                     (|(long_hit & pend_long)) || (push && fifo_full && !pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scan_q     <= IDLE;
            idx_q      <= '0;
            pend_press <= '0;
            pend_rel   <= '0;
            pend_long  <= '0;
            overflow_o <= 1'b0;
        end else begin
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            pend_press <= (pend_press & ~cons_press) | rise;
            pend_rel   <= (pend_rel & ~cons_rel) | fall;
            pend_long  <= (pend_long & ~cons_long) | long_hit;
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clear_ovf_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    capsense_evt_fifo #(
        .W     (IW + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i ({idx_q, push_kind}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_rdata)
    );

    assign evt_valid_o = !fifo_empty;
    assign evt_btn_o   = fifo_rdata[IW+1:2];
    assign evt_kind_o  = fifo_rdata[1:0];
    assign state_o     = state_q;

`ifdef CAPSENSE_TOGGLE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            toggle_o <= '0;
        end else begin
            toggle_o <= toggle_o ^ rise;
        end
    end
`endif

endmodule

// File: tb/tb_capsense_event_decoder.sv
// tb/tb_capsense_event_decoder.sv - self-checking bench for capsense_event_decoder
module tb_capsense_event_decoder;
    import capsense_pkg::*;

    localparam int DEB  = 3;
    localparam int LONG = 8;
    localparam int GAP  = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_stb = 1'b0;
    logic [3:0] buttons = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_btn;
    logic [1:0] evt_kind;
    logic [3:0] state;
    logic       overflow;
    logic       clear_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q [$];
    logic [3:0] pop_log [$];
    bit         mon_en = 1'b1;

    logic [3:0] m_state;
    int         m_run [4];
    int         m_since [4];
    bit         m_long_done [4];

    capsense_event_decoder #(
        .N(4), .DEB_SAMPLES(DEB), .LONG_SAMPLES(LONG), .FIFO_DEPTH(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sample_stb_i (sample_stb),
        .buttons_i    (buttons),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .evt_btn_o    (evt_btn),
        .evt_kind_o   (evt_kind),
        .state_o      (state),
        .overflow_o   (overflow),
        .clear_ovf_i  (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: events per strobe, listed in button order, each from the button's own history.
    task automatic model_reset();
        m_state = '0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]       = 0;
            m_since[i]     = 0;
            m_long_done[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] b);
        logic was;
        for (int i = 0; i < 4; i++) begin
            was = m_state[i];
            if (b[i] != m_state[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_run[i]   = 0;
                    m_state[i] = b[i];
                    if (b[i]) begin
                        exp_q.push_back({2'(i), EVT_PRESS});
                        m_since[i]     = 0;
                        m_long_done[i] = 1'b0;
                    end else begin
                        exp_q.push_back({2'(i), EVT_RELEASE});
                    end
                end
            end else begin
                m_run[i] = 0;
            end
            if (was && m_state[i]) begin
                m_since[i]++;
                if (m_since[i] == LONG && !m_long_done[i]) begin
                    exp_q.push_back({2'(i), EVT_LONG});
                    m_long_done[i] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            pop_log.push_back({evt_btn, evt_kind});
            if (mon_en) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL evt_unexpected: observed %0h expected none", {evt_btn, evt_kind});
                end
                if (exp_q.size() != 0) begin
                    check("evt_order", 16'({evt_btn, evt_kind}), 16'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic strobe(input logic [3:0] b);
        @(posedge clk); #1;
        sample_stb = 1'b1;
        buttons    = b;
        model_step(b);
        @(posedge clk); #1;
        sample_stb = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) strobe(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] rb;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_state", 16'(state), 16'h0);
        check("rst_valid", 16'(evt_valid), 16'h0);
        check("rst_ovf", 16'(overflow), 16'h0);
        check("rst_btn", 16'(evt_btn), 16'h0);
        check("rst_kind", 16'(evt_kind), 16'h0);

        strobes(4'b0000, 10);
        check("idle_state", 16'(state), 16'h0);
        check("idle_valid", 16'(evt_valid), 16'h0);
        check("idle_ovf", 16'(overflow), 16'h0);

        pop_log.delete();
        strobe(4'b0100);
        strobe(4'b0100);
        strobe(4'b0000);
        check("glitch_state", 16'(state), 16'h0);
        check("glitch_no_evt", 16'(pop_log.size()), 16'h0);
        strobes(4'b0100, 3);
        check("press2_state", 16'(state), 16'h4);
        check("press2_count", 16'(pop_log.size()), 16'h1);
        check("press2_evt", 16'(pop_log[0]), 16'h8);

        strobes(4'b0000, 3);
        pop_log.delete();
        strobes(4'b0010, 3);
        strobes(4'b0010, 7);
        check("long_not_yet", 16'(pop_log.size()), 16'h1);
        strobe(4'b0010);
        check("long_at_8", 16'(pop_log.size()), 16'h2);
        check("long_evt", 16'(pop_log[1]), 16'h6);
        strobes(4'b0010, 2);
        strobes(4'b0000, 3);
        check("long_seq_len", 16'(pop_log.size()), 16'h3);
        check("long_seq0", 16'(pop_log[0]), 16'h4);
        check("long_seq2", 16'(pop_log[2]), 16'h5);

        pop_log.delete();
        strobes(4'b1111, 3);
        check("all_state", 16'(state), 16'hf);
        check("all_len", 16'(pop_log.size()), 16'h4);
        for (int i = 0; i < 4; i++) check("all_order", 16'(pop_log[i]), 16'(i * 4));

        mon_en    = 1'b0;
        evt_ready = 1'b0;
        strobes(4'b0000, 3);
        strobes(4'b0001, 3);
        check("ovf_set", 16'(overflow), 16'h1);
        check("ovf_valid", 16'(evt_valid), 16'h1);
        check("ovf_head", 16'({evt_btn, evt_kind}), 16'h1);
        check("ovf_state", 16'(state), 16'h1);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_head_hold", 16'({evt_btn, evt_kind}), 16'h1);
        clear_ovf = 1'b1;
        @(posedge clk); #1;
        clear_ovf = 1'b0;
        check("ovf_clear", 16'(overflow), 16'h0);
        pop_log.delete();
        evt_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("drain_len", 16'(pop_log.size()), 16'h4);
        for (int i = 0; i < 4; i++) check("drain_order", 16'(pop_log[i]), 16'(i * 4 + 1));
        check("drain_empty", 16'(evt_valid), 16'h0);

        evt_ready = 1'b0;
        strobes(4'b0110, 3);
        check("pre_rst_valid", 16'(evt_valid), 16'h1);
        check("pre_rst_state", 16'(state), 16'h6);
        do_reset();
        check("mid_rst_valid", 16'(evt_valid), 16'h0);
        check("mid_rst_state", 16'(state), 16'h0);
        check("mid_rst_ovf", 16'(overflow), 16'h0);
        evt_ready = 1'b1;
        mon_en    = 1'b1;
        pop_log.delete();

        rb = '0;
        for (int s = 0; s < 250; s++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
            end
            strobe(rb);
            check("rand_state", 16'(state), 16'(m_state));
        end
        repeat (20) @(posedge clk);
        #1;
        check("rand_drained", 16'(exp_q.size()), 16'h0);
        check("rand_ovf", 16'(overflow), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
